dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to response valid (legal range 1..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00000000: byte address of word 0.
REQ-004 i_clk  input  1  sole clock, rising-edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req_valid  input  1  requester presents a request.
REQ-007 o_req_ready  output  1  responder can accept a request this cycle.
REQ-008 i_req_addr  input  32  byte address, word-aligned.
REQ-009 i_req_ren  input  1  read request.
REQ-010 i_req_wen  input  1  write request.
REQ-011 i_req_wdata  input  32  write data, byte lanes already positioned.
REQ-012 i_req_mask  input  4  byte-lane enables; bit n selects bits 8n+7:8n.
REQ-013 o_rsp_valid  output  1  response available.
REQ-014 i_rsp_ready  input  1  requester consumes the response.
REQ-015 o_rsp_rdata  output  32  read data; unmasked lanes are zero.
REQ-016 o_rsp_err  output  1  request was illegal; no memory side effect.

Function
REQ-017 States SHALL be IDLE, WAIT, RESP; o_req_ready = 1 only in IDLE.
REQ-018 Accept occurs on a rising edge with i_req_valid & o_req_ready; addr/ren/wen/wdata/mask are registered there; state goes IDLE->WAIT and a 4-bit counter loads LATENCY-1.
REQ-019 In WAIT the counter decrements each cycle; on the edge where it is 0 the state goes WAIT->RESP, so o_rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 Write commit SHALL happen on the WAIT->RESP edge, writing only the masked lanes of the registered wdata; unmasked lanes remain unchanged.
REQ-021 Read data SHALL be sampled on the WAIT->RESP edge into a register; o_rsp_rdata lanes not in mask = 0; for writes o_rsp_rdata = 0.
REQ-022 Error cases: ren & wen both 1; ren & wen both 0; addr[1:0] != 0; mask == 0; (addr-BASE_ADDR)>>2 >= DEPTH_WORDS or addr < BASE_ADDR.
REQ-023 On error: o_rsp_err = 1, no write, o_rsp_rdata = 0, same LATENCY timing.
REQ-024 o_rsp_valid, o_rsp_rdata, o_rsp_err SHALL hold stable in RESP until i_rsp_ready = 1; that edge returns to IDLE.
REQ-025 No back-to-back overlap: a new request accepts earliest the cycle after RESP->IDLE (one outstanding request max).
REQ-026 i_req_valid while not ready is ignored; the requester holds it.
REQ-027 i_rsp_ready outside RESP is ignored.
REQ-028 Read after write to the same word returns the newly written lanes.
REQ-029 Word index arithmetic SHALL use $clog2(DEPTH_WORDS) bits after the range check; no wrap-around aliasing.

Reset
REQ-030 i_rst asserted: state = IDLE, counter = 0, o_req_ready = 1 (after release), o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, immediately (asynchronous).
REQ-031 Reset in WAIT SHALL drop the pending request; an uncommitted write is never performed.
REQ-032 Memory array contents are not reset.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the state enum type and the mask-to-bit-enable expansion function.
REQ-034 One sub-module dmem_byte_ram: DEPTH_WORDS x 32 array, synchronous byte-masked write, registered read, no reset.

Verification
REQ-035 Reset, then write addr 0x10, wdata 0xDEADBEEF, mask 4'b1111; then read 0x10 mask 4'b1111 -> rdata 0xDEADBEEF, err 0, valid 2 cycles after each accept.
REQ-036 Word 0x20 = 0x11223344; write mask 4'b1100 wdata 0xAABB0000; read mask 4'b1111 -> 0xAABB3344; read mask 4'b0010 -> 0x00003300.
REQ-037 Request with addr 0x13, ren 1 -> err 1, rdata 0; subsequent read of 0x10 unchanged.
REQ-038 Request with ren=wen=1, then addr 4*DEPTH_WORDS, then mask 0 -> err 1 each, memory unchanged.
REQ-039 Hold i_rsp_ready=0 for 5 cycles in RESP -> rdata/err stable, o_req_ready 0 throughout; accept next request only after ready handshake.
REQ-040 Assert i_rst one cycle after accepting a write of 0xCAFEF00D to 0x40 (LATENCY 2) -> outputs zero at once, later read of 0x40 returns prior value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // Responder handshake states: idle, latency countdown, response held.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Expand a 4-bit byte-lane mask into a 32-bit per-bit enable.
  function automatic logic [31:0] mask_bits(input logic [3:0] mask);
    logic [31:0] bits;
    bits = '0;
    for (int b = 0; b < 4; b++) bits[8*b +: 8] = {8{mask[b]}};
    return bits;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed storage with per-bit write enable and registered read.
// The read samples the pre-write contents on a shared edge.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   bit_en,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Masked write merges new lanes into the stored word; read is registered.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= (mem[addr] & ~bit_en) | (wdata & bit_en);
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  state_t        state, next;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_r;
  logic          ren_r, wen_r, err_r;
  logic [31:0]   wdata_r;
  logic [3:0]    mask_r;
  logic [31:0]   ram_q;
  logic [31:0]   offset;
  logic          req_err, accept, commit;

  assign accept = i_req_valid && o_req_ready;
  assign commit = (state == ST_WAIT) && (cnt == 4'd0);
  assign offset = i_req_addr - BASE_ADDR;

  // Legality is decided at accept time so the range check happens before
  // the offset is truncated to a word index (no aliasing).
  assign req_err = (i_req_ren == i_req_wen) || (i_req_addr[1:0] != 2'b00) ||
                   (i_req_mask == 4'b0000) || (i_req_addr < BASE_ADDR) ||
                   ((offset >> 2) >= DEPTH32);

  // State register and latency counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next;
      if (accept)                             cnt <= LAT_M1;
      else if (state == ST_WAIT && cnt != 0)  cnt <= cnt - 4'd1;
    end
  end

  // Capture the request fields on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_r   <= '0;
      ren_r   <= 1'b0;
      wen_r   <= 1'b0;
      err_r   <= 1'b0;
      wdata_r <= '0;
      mask_r  <= '0;
    end else if (accept) begin
      idx_r   <= offset[AW+1:2];
      ren_r   <= i_req_ren;
      wen_r   <= i_req_wen;
      err_r   <= req_err;
      wdata_r <= i_req_wdata;
      mask_r  <= i_req_mask;
    end
  end

  // Next-state logic; rsp_ready outside RESP and valid outside IDLE are ignored.
  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (i_req_valid)    next = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0)    next = ST_RESP;
      ST_RESP: if (i_rsp_ready)    next = ST_IDLE;
      default:                     next = ST_IDLE;
    endcase
  end

  dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (i_clk),
    .we    (commit && wen_r && !err_r),
    .re    (commit && ren_r && !err_r),
    .addr  (idx_r),
    .wdata (wdata_r),
    .bit_en(mask_bits(mask_r)),
    .rdata (ram_q)
  );

  // Outputs decode from state so reset clears them immediately.
  assign o_req_ready = (state == ST_IDLE);
  assign o_rsp_valid = (state == ST_RESP);
  assign o_rsp_err   = (state == ST_RESP) && err_r;
  assign o_rsp_rdata = ((state == ST_RESP) && ren_r && !err_r) ?
                       (ram_q & mask_bits(mask_r)) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: stimulus pushes expected responses, a monitor pops and
// compares at each response handshake.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int DW  = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ren = 1'b0;
  logic        i_req_wen = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_mask = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_ren(i_req_ren), .i_req_wen(i_req_wen),
    .i_req_wdata(i_req_wdata), .i_req_mask(i_req_mask),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: compare on each handshake cycle.
  always @(negedge i_clk) begin
    if (!i_rst && o_rsp_valid && i_rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e.rdata);
        chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 50 && !o_req_ready; k++) begin
      @(posedge i_clk); #1;
    end
    if (!o_req_ready) chk("ready_timeout", 32'(o_req_ready), 32'd1);
  endtask

  // Issue one request, check latency, optionally stall the response.
  task automatic do_req(input logic [31:0] addr, input logic ren, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold);
    exp_t e;
    wait_ready();
    i_req_valid = 1'b1; i_req_addr = addr; i_req_ren = ren; i_req_wen = wen;
    i_req_wdata = wdata; i_req_mask = mask;
    e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_rsp_ready = (hold == 0);
    for (int c = 0; c <= LAT; c++) begin
      @(negedge i_clk);
      chk("rsp_latency", 32'(o_rsp_valid), 32'(c == LAT));
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_rdata", o_rsp_rdata, exp_rdata);
      chk("hold_err", 32'(o_rsp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
      @(posedge i_clk); #1;
      if (h == hold - 1) i_rsp_ready = 1'b1;
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    chk("post_hs_valid", 32'(o_rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rdata", o_rsp_rdata, 32'd0);
    chk("rst_err", 32'(o_rsp_err), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_ready", 32'(o_req_ready), 32'd1);

    // Basic write/read
    do_req(32'h10, 0, 1, 32'hDEADBEEF, 4'b1111, 32'h0,        0, 0);
    do_req(32'h10, 1, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0, 0);
    // Partial-lane write and masked reads
    do_req(32'h20, 0, 1, 32'h11223344, 4'b1111, 32'h0,        0, 0);
    do_req(32'h20, 0, 1, 32'hAABB0000, 4'b1100, 32'h0,        0, 0);
    do_req(32'h20, 1, 0, 32'h0,        4'b1111, 32'hAABB3344, 0, 0);
    do_req(32'h20, 1, 0, 32'h0,        4'b0010, 32'h00003300, 0, 0);
    // Illegal requests
    do_req(32'h13, 1, 0, 32'h0,        4'b1111, 32'h0,        1, 0);
    do_req(32'h10, 1, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0, 0);
    do_req(32'h10, 1, 1, 32'h0,        4'b1111, 32'h0,        1, 0);
    do_req(32'h1000, 0, 1, 32'h0,      4'b1111, 32'h0,        1, 0);
    do_req(32'h10, 0, 1, 32'h0,        4'b0000, 32'h0,        1, 0);
    do_req(32'h10, 0, 0, 32'h0,        4'b1111, 32'h0,        1, 0);
    do_req(32'h1000, 1, 0, 32'h0,      4'b1111, 32'h0,        1, 0);
    // Memory unchanged after errors; stalled responses stay stable
    do_req(32'h10, 1, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0, 5);
    do_req(32'h20, 1, 0, 32'h0,        4'b1111, 32'hAABB3344, 0, 5);
    // Last word in range
    do_req(32'hFFC, 0, 1, 32'h5A5A5A5A, 4'b1111, 32'h0,       0, 0);
    do_req(32'hFFC, 1, 0, 32'h0,        4'b0101, 32'h005A005A, 0, 0);
    // Prior value for the reset-abort check
    do_req(32'h40, 0, 1, 32'h01020304, 4'b1111, 32'h0,        0, 0);

    // Reset while a write is pending: it must never commit.
    wait_ready();
    i_req_valid = 1'b1; i_req_addr = 32'h40; i_req_ren = 1'b0; i_req_wen = 1'b1;
    i_req_wdata = 32'hCAFEF00D; i_req_mask = 4'b1111;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("pend_ready", 32'(o_req_ready), 32'd0);
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("async_rst_rdata", o_rsp_rdata, 32'd0);
    chk("async_rst_err", 32'(o_rsp_err), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rel_ready", 32'(o_req_ready), 32'd1);
    do_req(32'h40, 1, 0, 32'h0, 4'b1111, 32'h01020304, 0, 0);

    repeat (3) @(posedge i_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
